// File: rtl/addsub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package addsub_pkg;

  localparam int ADDSUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

endpackage

// File: rtl/serial_addsub_ctrl_fulladder.sv
// One-bit full adder cell, reused every cycle by the serial controller.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: streams operands LSB-first through one
// full adder, with a start/busy/done handshake around the sequence.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

  addsub_state_t state, next_state;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             cm;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;

  fulladder u_fa (
    .A   (sa[0]),
    .B   (sb[0]),
    .Cin (c),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  // A new operation is only taken when no bits are in flight.
  assign accept = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CNT_LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtraction is A + ~B + 1: invert B at load time and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      cm       <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sa       <= a;
      sb       <= b ^ {WIDTH{sub}};
      c        <= sub;
      cm       <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      sa     <= {1'b0, sa[WIDTH-1:1]};
      sb     <= {1'b0, sb[WIDTH-1:1]};
      result <= {fa_sum, result[WIDTH-1:1]};
      c      <= fa_cout;
      if (cnt == CNT_MSB_IN) begin
        cm <= fa_cout;
      end
      if (cnt == CNT_LAST) begin
        cout     <= fa_cout;
        overflow <= cm ^ fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed, table-driven bench for serial_addsub_ctrl at WIDTH = 8.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_result;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Launch one operation, scramble the inputs mid-run, and wait (bounded) for done.
  task automatic apply_stimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                                output int lat, output int busy_cycles);
    a = va; b = vb; sub = vsub; start = 1'b1;
    tick();
    start = 1'b0; a = ~va; b = ~vb; sub = ~vsub;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc, done_cnt, done_cyc, last_busy;
    logic [W-1:0] first_res;

    vecs.push_back('{8'd100, 8'd27, 1'b0, 8'h7F, 1'b0, 1'b0});
    vecs.push_back('{8'h7F,  8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'hFF,  8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'd5,   8'd7,  1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80,  8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h00,  8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h80,  8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h55,  8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h10,  8'h20, 1'b1, 8'hF0, 1'b0, 1'b0});

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_result", 32'(result), 32'd0);
    check_output("reset_cout", 32'(cout), 32'd0);
    check_output("reset_ovf", 32'(overflow), 32'd0);

    // Reset beats a coincident start.
    start = 1'b1; a = 8'd1; b = 8'd1;
    tick();
    check_output("reset_start_busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat, bc);
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'(W + 1));
      check_output($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(W));
      check_output($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_result));
      check_output($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check_output($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      tick();
      check_output($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check_output($sformatf("v%0d_held", i), 32'(result), 32'(vecs[i].exp_result));
    end

    // Start while busy is ignored.
    a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0; done_cyc = 0; last_busy = 0; first_res = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 4) begin
        a = 8'h11; b = 8'h22; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) last_busy = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        first_res = result;
      end
      tick();
    end
    check_output("ignore_done_count", 32'(done_cnt), 32'd1);
    check_output("ignore_done_cycle", 32'(done_cyc), 32'd9);
    check_output("ignore_last_busy", 32'(last_busy), 32'd8);
    check_output("ignore_result", 32'(first_res), 32'h7F);

    // Back-to-back: start held from the last RUN cycle through DONE.
    a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = 0; done_cnt = 0; first_res = '0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc == 8) begin
        a = 8'd3; b = 8'd4; sub = 1'b0; start = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          first_res = result;
        end else if (done_cnt == 2) begin
          check_output("b2b_gap", 32'(cyc - done_cyc), 32'(W + 1));
          check_output("b2b_result", 32'(result), 32'd7);
        end
      end
      if (cyc == 10) begin
        check_output("b2b_busy_after_done", 32'(busy), 32'd1);
        start = 1'b0;
      end
      tick();
    end
    check_output("b2b_first_result", 32'(first_res), 32'h7F);
    check_output("b2b_done_count", 32'(done_cnt), 32'd2);

    // Reset asserted in cycle 5 of a run aborts it.
    a = 8'hFF; b = 8'hFF; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_result", 32'(result), 32'd0);
    check_output("abort_cout", 32'(cout), 32'd0);
    check_output("abort_ovf", 32'(overflow), 32'd0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done) done_cnt++;
      tick();
    end
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    apply_stimulus(8'd1, 8'd1, 1'b0, lat, bc);
    check_output("after_abort_latency", 32'(lat), 32'(W + 1));
    check_output("after_abort_result", 32'(result), 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial adder/subtractor controller that time-shares one `fulladder` cell across all operand bits. It sequences the cell LSB-first over WIDTH cycles and handles two's-complement subtraction through operand inversion and carry-in. It sits beside the parallel adder/subtractor as an area-minimal alternative, exposing a start/busy/done handshake to the surrounding control logic.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request a new operation; sampled only when not busy.
- `sub`: input, 1 bit. 0 = A+B, 1 = A−B; sampled with `start`.
- `a`: input, WIDTH bits. Operand A; sampled with `start`.
- `b`: input, WIDTH bits. Operand B; sampled with `start`.
- `busy`: output, 1 bit. High while bits are being processed.
- `done`: output, 1 bit. One-cycle pulse when the result is valid.
- `result`: output, WIDTH bits. Sum or difference; held until the next accepted `start`.
- `cout`: output, 1 bit. Carry out of the MSB; for subtraction, 1 = no borrow.
- `overflow`: output, 1 bit. Signed overflow: carry into MSB XOR carry out of MSB.

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `start` = 1: latch `a` into shift register SA and `b ^ {WIDTH{sub}}` into SB.
  - Set carry register C = `sub`, bit counter = 0, `result` = 0, `cout` = 0, `overflow` = 0.
  - Go to RUN.
- **RUN** (each cycle)
  - Drive `fulladder` with SA[0], SB[0], C.
  - Shift SA and SB right by one.
  - Shift `result` right, inserting Sum at the MSB.
  - C ← Cout.
  - When counter = WIDTH−2, capture C (carry into MSB) in register CM.
  - When counter = WIDTH−1, go to DONE and set `cout` = Cout and `overflow` = CM ^ Cout. Otherwise increment the counter.
- **DONE**
  - `done` = 1 for exactly this cycle.
  - If `start` = 1: accept a new operation as in IDLE (back-to-back) and go to RUN.
  - Otherwise go to IDLE.
- `start` during RUN is ignored; there is no queueing.
- `sub` is sampled only with an accepted `start`. Changing `sub`, `a` or `b` mid-run has no effect.
- Counter width is `$clog2(WIDTH)`. No wrap beyond WIDTH−1 is permitted.
- Arithmetic is modulo 2^WIDTH. `cout` and `overflow` report the unsigned and signed view respectively.

## Timing
- Reset values: state = IDLE; `busy`, `done`, `cout`, `overflow` = 0; `result` = 0; internal registers = 0.
- Reset mid-RUN or in DONE aborts the operation. The next cycle is IDLE with all outputs at reset values, and no `done` pulse is issued.
- Latency, with `start` accepted at the edge ending cycle 0:
  - `busy` is high in cycles 1..WIDTH.
  - `done` is high in cycle WIDTH+1.
  - `result`, `cout` and `overflow` are valid from cycle WIDTH+1 until the next accepted `start`.
- Back-to-back: `start` high in the DONE cycle gives `busy` in the next cycle. Throughput is one operation per WIDTH+1 cycles.
- `busy` = (state == RUN) and `done` = (state == DONE). Both are registered state decodes with no combinational path from inputs.
- Simultaneous `reset` and `start`: reset wins.

## Structure
- Package `addsub_pkg`:
  - state enum `addsub_state_t` {IDLE, RUN, DONE};
  - localparam `ADDSUB_DEFAULT_WIDTH` = 8.
- Single sub-module: one instance of `fulladder` (ports A, B, Cin, Sum, Cout), fed from SA[0], SB[0] and C.
- Everything else (FSM, shift registers, counter, flag capture) lives in one sequential block plus the next-state logic.

## Test plan
All scenarios use WIDTH = 8.
1. Add, no overflow: `a`=100, `b`=27, `sub`=0 → `done` in cycle 9; `result`=0x7F, `cout`=0, `overflow`=0.
2. Signed overflow on add: `a`=0x7F, `b`=0x01, `sub`=0 → `result`=0x80, `cout`=0, `overflow`=1. Also `a`=0xFF, `b`=0x01 → `result`=0x00, `cout`=1, `overflow`=0.
3. Subtract: `a`=5, `b`=7, `sub`=1 → `result`=0xFE, `cout`=0, `overflow`=0. Also `a`=0x80, `b`=0x01, `sub`=1 → `result`=0x7F, `cout`=1, `overflow`=1.
4. Start while busy: pulse `start` with new operands in cycle 4 of a run → ignored; the first result is unchanged, exactly one `done`, and `busy` drops after cycle 8.
5. Back-to-back: hold `start` high through the DONE cycle with 3+4 → second `done` 9 cycles after the first; `result`=7.
6. Reset mid-RUN: assert `reset` in cycle 5 → next cycle state = IDLE, all outputs 0, no `done`; a subsequent 1+1 completes normally with `result`=2.
